// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Expands per-byte enables into a per-bit write mask.
  function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [WORD_W-1:0] mask;
    mask = {WORD_W{1'b0}};
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed storage: synchronous byte-enabled write, combinational read, no reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] mask_s;

  assign mask_s = be_mask(be);
  assign rdata  = mem_r[addr];

  // Merge only the enabled bytes into the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= (mem_r[addr] & ~mask_s) | (wdata & mask_s);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time, LATENCY wait states, then a held
// response on a second valid/ready channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               AW          = $clog2(DEPTH);
  localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  dmem_state_e       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [WORD_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  logic              err_s;
  logic              access_s;
  logic              bank_we_s;
  logic [AW-1:0]     idx_s;
  logic [WORD_W-1:0] bank_rdata_s;

  assign err_s     = (addr_r[1:0] != 2'b00) || (addr_r[31:2] >= DEPTH_WORDS);
  assign access_s  = (state_r == BUSY) && (cnt_r == CNT_ZERO);
  assign bank_we_s = access_s && we_r && !err_s;
  assign idx_s     = addr_r[2 +: AW];

  dmem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we_s),
    .addr  (idx_s),
    .wdata (wdata_r),
    .be    (be_r),
    .rdata (bank_rdata_s)
  );

  // Request/response FSM; the store commits on the same edge that loads the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= {WORD_W{1'b0}};
      be_r        <= {BE_W{1'b0}};
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORD_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!req_ready_r) begin
            req_ready_r <= 1'b1;
          end else if (req_valid) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            be_r        <= req_be;
            cnt_r       <= CNT_LOAD;
            req_ready_r <= 1'b0;
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_ZERO) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || we_r) ? {WORD_W{1'b0}} : bank_rdata_s;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {WORD_W{1'b0}};
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: cycle-timed transaction model checked every cycle,
// plus directed literal expectations and randomized traffic.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int NW    = 16;
  localparam int INF   = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction described by its acceptance time; the memory effect
  // and result appear LAT edges later, the response holds until the handshake.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          in_reset = 1'b1;
  bit          outstanding = 1'b0;
  int          t_acc = 0;
  int          ready_from = INF;
  bit          acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_err = 1'b0;
  bit          exp_dc = 1'b0;
  bit          e_valid, e_ready;

  task automatic resolve();
    int w;
    w = int'(acc_addr / 4);
    exp_dc = 1'b0;
    if ((acc_addr % 4) != 0 || acc_addr >= 32'(DEPTH * 4)) begin
      exp_err = 1'b1;
      exp_rdata = 32'h0;
    end else if (acc_we) begin
      exp_err = 1'b0;
      exp_rdata = 32'h0;
      for (int b = 0; b < 4; b++)
        if (acc_be[b]) m_mem[w][8*b +: 8] = acc_wdata[8*b +: 8];
      if (acc_be == 4'hF) m_known[w] = 1'b1;
    end else begin
      exp_err = 1'b0;
      exp_rdata = m_mem[w];
      exp_dc = !m_known[w];
    end
  endtask

  // Compare outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      e_valid = 1'b0;
      e_ready = 1'b0;
    end else begin
      e_valid = outstanding && (cyc >= t_acc + LAT);
      e_ready = !outstanding && (cyc >= ready_from);
    end
    chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_valid && exp_err});
    if (!(e_valid && exp_dc)) chk("rsp_rdata", rsp_rdata, e_valid ? exp_rdata : 32'h0);

    if (!rst) begin
      outstanding = 1'b0;
      in_reset = 1'b1;
      ready_from = INF;
    end else if (in_reset) begin
      in_reset = 1'b0;
      ready_from = cyc + 1;
    end else if (outstanding && (cyc + 1 == t_acc + LAT)) begin
      resolve();
    end else if (e_valid && rsp_ready) begin
      outstanding = 1'b0;
      ready_from = cyc + 1;
    end else if (e_ready && req_valid) begin
      outstanding = 1'b1;
      t_acc = cyc + 1;
      acc_we = req_we;
      acc_addr = req_addr;
      acc_wdata = req_wdata;
      acc_be = req_be;
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int bp, input bit noise,
                     output logic [31:0] rd, output bit er, output int lat);
    int n;
    int t0;
    rd = 32'h0; er = 1'b0; lat = -1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    rsp_ready = (bp == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    t0 = cyc;
    req_valid = noise;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      return;
    end
    lat = cyc - t0;
    rd = rsp_rdata;
    er = rsp_err;
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // Reset held three cycles
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready_early", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Prefill the working set of words
    for (int i = 0; i < NW; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0, rd, er, lat);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat);
    chk("st_lat", 32'(lat), 32'(LAT));
    chk("st_err", {31'd0, er}, 32'd0);
    chk("st_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    chk("ld_lat", 32'(lat), 32'(LAT));
    chk("ld_rdata", rd, 32'hDEADBEEF);
    txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, 1'b0, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    chk("partial_rdata", rd, 32'hDEADAAEF);
    txn(1'b0, 32'h12, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    chk("misalign_err", {31'd0, er}, 32'd1);
    chk("misalign_rdata", rd, 32'h0);
    txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    chk("range_err", {31'd0, er}, 32'd1);
    chk("range_rdata", rd, 32'h0);
    txn(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, lat);
    chk("err_store_err", {31'd0, er}, 32'd1);
    txn(1'b1, 32'h10, 32'h12345678, 4'h0, 0, 1'b0, rd, er, lat);
    chk("be0_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
    chk("bp_rdata", rd, 32'hDEADAAEF);

    // Reset while a store is still waiting
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h00001234; req_be = 4'hF;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(posedge clk); #1 rsp_ready = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    chk("rst_busy_rdata", rd, 32'hCAFEF00D);

    // Randomized traffic over the working set with occasional bad addresses
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'($urandom_range(0, NW * 4 - 1)) | 32'h1;
      else if (sel == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095)) * 4;
      else               a = 32'($urandom_range(0, NW - 1)) * 4;
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
          1'($urandom), rd, er, lat);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
